// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side stream signals for the
// UART transmit arbiter, plus the grant status outputs.
//
// Handshake: a byte moves on a rising clk edge exactly when valid and ready
// are both high on that edge; a source holding valid keeps its data stable
// until that edge, and ready may be driven independently of valid.
//
// Modport master is the arbiter's view; modport slave is the view of the
// surrounding logic that feeds requesters and consumes the output stream.
interface uart_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PORTS      = 4
);
   localparam int IDX_W = $clog2(PORTS);

   logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [PORTS-1:0]            s_axis_tvalid;
   logic [PORTS-1:0]            s_axis_tlast;
   logic [PORTS-1:0]            s_axis_tready;
   logic [DATA_WIDTH-1:0]       m_axis_tdata;
   logic                        m_axis_tvalid;
   logic                        m_axis_tready;
   logic                        grant_valid;
   logic [IDX_W-1:0]            grant_index;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_index
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_index
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges PORTS byte streams into one UART transmit
// stream. A port owns the output for a whole frame (until its tlast beat);
// optionally a tag byte TAG_BASE|port is sent ahead of each frame.
// state_dbg exposes the FSM state: 0=IDLE, 1=HEADER, 2=DATA.
module uart_tx_arbiter #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    PORTS      = 4,
   parameter bit                    HEADER_EN  = 1'b1,
   parameter logic [DATA_WIDTH-1:0] TAG_BASE   = 8'hA0
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_arbiter_if.master  bus,
   output logic [1:0]         state_dbg
);
   localparam int IDX_W = $clog2(PORTS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      grant_index_q;
   logic                  grant_valid_q;
   logic [IDX_W-1:0]      last_grant;

   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;

   logic [DATA_WIDTH-1:0] g_data;
   logic                  g_valid;
   logic                  g_last;

   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic [PORTS-1:0]      s_ready;

   // Round-robin search starting just after the previous owner, wrapping.
   always_comb begin
      int unsigned cand;
      logic [IDX_W-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= PORTS; i++) begin
         cand     = (int'(last_grant) + i) % PORTS;
         cand_idx = IDX_W'(cand);
         if (!pick_found && bus.s_axis_tvalid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Select the granted port's byte, valid and last flags.
   always_comb begin
      g_data  = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_index_q == IDX_W'(i)) begin
            g_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            g_valid = bus.s_axis_tvalid[i];
            g_last  = bus.s_axis_tlast[i];
         end
      end
   end

   // Output stream and per-port ready as a function of state; DATA is a
   // straight pass-through so no byte is buffered inside the arbiter.
   always_comb begin
      m_data  = '0;
      m_valid = 1'b0;
      s_ready = '0;
      case (state)
         HEADER: begin
            m_valid = 1'b1;
            m_data  = TAG_BASE | DATA_WIDTH'(grant_index_q);
         end
         DATA: begin
            m_valid                = g_valid;
            m_data                 = g_data;
            s_ready[grant_index_q] = bus.m_axis_tready;
         end
         default: begin
            m_valid = 1'b0;
         end
      endcase
   end

   // Arbitration FSM: pick in IDLE, optional tag beat, then hold the grant
   // until the owner's tlast beat is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant_valid_q <= 1'b0;
         grant_index_q <= '0;
         last_grant    <= IDX_W'(PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_index_q <= pick_idx;
                  grant_valid_q <= 1'b1;
                  state         <= HEADER_EN ? HEADER : DATA;
               end
            end
            HEADER: begin
               if (bus.m_axis_tready) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (g_valid && bus.m_axis_tready && g_last) begin
                  last_grant    <= grant_index_q;
                  grant_valid_q <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.m_axis_tdata  = m_data;
   assign bus.m_axis_tvalid = m_valid;
   assign bus.s_axis_tready = s_ready;
   assign bus.grant_valid   = grant_valid_q;
   assign bus.grant_index   = grant_index_q;
   assign state_dbg         = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with tag bytes enabled
// and one without, driven on the falling edge and checked 1 ns later.
module tb_uart_tx_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state1;
   logic [1:0] state2;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];

   uart_tx_arbiter_if #(.DATA_WIDTH(8), .PORTS(4)) bus1 ();
   uart_tx_arbiter_if #(.DATA_WIDTH(8), .PORTS(4)) bus2 ();

   uart_tx_arbiter #(.DATA_WIDTH(8), .PORTS(4), .HEADER_EN(1'b1), .TAG_BASE(8'hA0)) dut (
      .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state1)
   );

   uart_tx_arbiter #(.DATA_WIDTH(8), .PORTS(4), .HEADER_EN(1'b0), .TAG_BASE(8'hA0)) dut_nohdr (
      .clk(clk), .rst(rst), .bus(bus2), .state_dbg(state2)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive1(input int p, input logic [7:0] d, input logic v, input logic l);
      bus1.s_axis_tdata[p*8 +: 8] = d;
      bus1.s_axis_tvalid[p]       = v;
      bus1.s_axis_tlast[p]        = l;
   endtask

   task automatic clear_inputs();
      bus1.s_axis_tdata  = '0;
      bus1.s_axis_tvalid = '0;
      bus1.s_axis_tlast  = '0;
      bus1.m_axis_tready = 1'b1;
      bus2.s_axis_tdata  = '0;
      bus2.s_axis_tvalid = '0;
      bus2.s_axis_tlast  = '0;
      bus2.m_axis_tready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();

      // ---- reset values
      @(negedge clk); #1;
      chk("rst_m_tvalid", bus1.m_axis_tvalid, 0);
      chk("rst_s_tready", bus1.s_axis_tready, 0);
      chk("rst_grant_valid", bus1.grant_valid, 0);
      chk("rst_grant_index", bus1.grant_index, 0);
      chk("rst_state", state1, 0);
      rst = 1'b0;

      // ---- single port 2 frame 11,22,33
      @(negedge clk); drive1(2, 8'h11, 1, 0); #1;
      chk("p2_idle_tvalid", bus1.m_axis_tvalid, 0);
      chk("p2_idle_tready", bus1.s_axis_tready, 0);
      @(negedge clk); #1;
      chk("p2_hdr_tvalid", bus1.m_axis_tvalid, 1);
      chk("p2_hdr_tdata", bus1.m_axis_tdata, 8'hA2);
      chk("p2_hdr_gidx", bus1.grant_index, 2);
      chk("p2_hdr_gvalid", bus1.grant_valid, 1);
      chk("p2_hdr_state", state1, 1);
      @(negedge clk); #1;
      chk("p2_d0_tdata", bus1.m_axis_tdata, 8'h11);
      chk("p2_d0_tready", bus1.s_axis_tready, 4'b0100);
      @(negedge clk); drive1(2, 8'h22, 1, 0); #1;
      chk("p2_d1_tdata", bus1.m_axis_tdata, 8'h22);
      chk("p2_d1_gidx", bus1.grant_index, 2);
      @(negedge clk); drive1(2, 8'h33, 1, 1); #1;
      chk("p2_d2_tdata", bus1.m_axis_tdata, 8'h33);
      chk("p2_d2_gvalid", bus1.grant_valid, 1);
      @(negedge clk); drive1(2, 8'h00, 0, 0); #1;
      chk("p2_end_gvalid", bus1.grant_valid, 0);
      chk("p2_end_tvalid", bus1.m_axis_tvalid, 0);
      chk("p2_end_state", state1, 0);

      // ---- all ports, 1-byte frames: A0,A1,A2,A3,A0 with idle gaps
      do_reset();
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(8'hA0 | 8'(k % 4));
         exp_q.push_back(8'h10 + 8'(k % 4));
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         for (int p = 0; p < 4; p++) drive1(p, 8'h10 + 8'(p), 1, 1);
         #1;
         chk("rr_idle_tvalid", bus1.m_axis_tvalid, 0);
         @(negedge clk); #1;
         chk("rr_hdr_tvalid", bus1.m_axis_tvalid, 1);
         chk("rr_hdr_tdata", bus1.m_axis_tdata, exp_q.pop_front());
         chk("rr_hdr_gidx", bus1.grant_index, k % 4);
         @(negedge clk); #1;
         chk("rr_data_tdata", bus1.m_axis_tdata, exp_q.pop_front());
      end
      chk("rr_queue_empty", exp_q.size(), 0);

      // ---- backpressure on a port 1 frame 55,66 (last grant was 0)
      @(negedge clk);
      for (int p = 0; p < 4; p++) drive1(p, 8'h00, 0, 0);
      drive1(1, 8'h55, 1, 0);
      bus1.m_axis_tready = 1'b0; #1;
      chk("bp_idle_tvalid", bus1.m_axis_tvalid, 0);
      @(negedge clk); #1;
      chk("bp_hdr_stall_tdata", bus1.m_axis_tdata, 8'hA1);
      chk("bp_hdr_stall_state", state1, 1);
      @(negedge clk); bus1.m_axis_tready = 1'b1; #1;
      chk("bp_hdr_go_tdata", bus1.m_axis_tdata, 8'hA1);
      @(negedge clk); bus1.m_axis_tready = 1'b0; #1;
      chk("bp_d0_stall_tdata", bus1.m_axis_tdata, 8'h55);
      chk("bp_d0_stall_tready", bus1.s_axis_tready, 4'b0000);
      @(negedge clk); bus1.m_axis_tready = 1'b1; #1;
      chk("bp_d0_go_tdata", bus1.m_axis_tdata, 8'h55);
      chk("bp_d0_go_tready", bus1.s_axis_tready, 4'b0010);
      @(negedge clk); drive1(1, 8'h66, 1, 1); bus1.m_axis_tready = 1'b0; #1;
      chk("bp_d1_stall_tdata", bus1.m_axis_tdata, 8'h66);
      chk("bp_d1_stall_tready", bus1.s_axis_tready, 4'b0000);
      @(negedge clk); bus1.m_axis_tready = 1'b1; #1;
      chk("bp_d1_go_tdata", bus1.m_axis_tdata, 8'h66);
      chk("bp_d1_go_tready", bus1.s_axis_tready, 4'b0010);
      @(negedge clk); drive1(1, 8'h00, 0, 0); #1;
      chk("bp_end_gvalid", bus1.grant_valid, 0);

      // ---- grant lock: port 0 pauses mid-frame while port 3 requests
      @(negedge clk); drive1(0, 8'h01, 1, 0); #1;
      chk("lk_idle_tvalid", bus1.m_axis_tvalid, 0);
      @(negedge clk); drive1(3, 8'h33, 1, 1); #1;
      chk("lk_hdr_tdata", bus1.m_axis_tdata, 8'hA0);
      @(negedge clk); #1;
      chk("lk_d0_tdata", bus1.m_axis_tdata, 8'h01);
      chk("lk_d0_gidx", bus1.grant_index, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); drive1(0, 8'h00, 0, 0); #1;
         chk("lk_gap_tvalid", bus1.m_axis_tvalid, 0);
         chk("lk_gap_gidx", bus1.grant_index, 0);
         chk("lk_gap_tready", bus1.s_axis_tready, 4'b0001);
      end
      @(negedge clk); drive1(0, 8'h02, 1, 1); #1;
      chk("lk_d1_tdata", bus1.m_axis_tdata, 8'h02);
      chk("lk_d1_gidx", bus1.grant_index, 0);
      @(negedge clk); drive1(0, 8'h00, 0, 0); #1;
      chk("lk_idle2_tvalid", bus1.m_axis_tvalid, 0);
      @(negedge clk); #1;
      chk("lk_p3_hdr_tdata", bus1.m_axis_tdata, 8'hA3);
      chk("lk_p3_hdr_gidx", bus1.grant_index, 3);
      @(negedge clk); #1;
      chk("lk_p3_d_tdata", bus1.m_axis_tdata, 8'h33);
      @(negedge clk); drive1(3, 8'h00, 0, 0); #1;
      chk("lk_end_gvalid", bus1.grant_valid, 0);

      // ---- reset during DATA of port 1
      @(negedge clk); drive1(1, 8'h77, 1, 0); #1;
      chk("rs_idle_tvalid", bus1.m_axis_tvalid, 0);
      @(negedge clk); #1;
      chk("rs_hdr_tdata", bus1.m_axis_tdata, 8'hA1);
      @(negedge clk); #1;
      chk("rs_d0_tdata", bus1.m_axis_tdata, 8'h77);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;
      chk("rs_m_tvalid", bus1.m_axis_tvalid, 0);
      chk("rs_s_tready", bus1.s_axis_tready, 0);
      chk("rs_gvalid", bus1.grant_valid, 0);
      chk("rs_gidx", bus1.grant_index, 0);
      chk("rs_state", state1, 0);
      rst = 1'b0;
      drive1(0, 8'h44, 1, 1); #1;
      chk("rs_idle_tvalid2", bus1.m_axis_tvalid, 0);
      @(negedge clk); #1;
      chk("rs_regrant_tdata", bus1.m_axis_tdata, 8'hA0);
      chk("rs_regrant_gidx", bus1.grant_index, 0);

      // ---- no-header build: port 3 single byte 5A
      do_reset();
      @(negedge clk);
      bus2.s_axis_tdata[3*8 +: 8] = 8'h5A;
      bus2.s_axis_tvalid[3]       = 1'b1;
      bus2.s_axis_tlast[3]        = 1'b1;
      #1;
      chk("nh_idle_tvalid", bus2.m_axis_tvalid, 0);
      @(negedge clk); #1;
      chk("nh_tvalid", bus2.m_axis_tvalid, 1);
      chk("nh_tdata", bus2.m_axis_tdata, 8'h5A);
      chk("nh_gidx", bus2.grant_index, 3);
      chk("nh_state", state2, 2);
      chk("nh_tready", bus2.s_axis_tready, 4'b1000);
      @(negedge clk); bus2.s_axis_tvalid = '0; bus2.s_axis_tlast = '0; #1;
      chk("nh_end_tvalid", bus2.m_axis_tvalid, 0);
      chk("nh_end_gvalid", bus2.grant_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width of every data path.
REQ-002 Parameter PORTS, default 4: number of requester ports, legal range 2..8.
REQ-003 Parameter HEADER_EN, default 1: when 1, one port-tag byte is emitted before each frame.
REQ-004 Parameter TAG_BASE, default 8'hA0: tag byte value = TAG_BASE | port index.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_axis_tdata  input  PORTS*DATA_WIDTH  requester bytes; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_axis_tvalid  input  PORTS  per-port valid.
REQ-009 s_axis_tlast  input  PORTS  per-port end-of-frame marker.
REQ-010 s_axis_tready  output  PORTS  per-port ready.
REQ-011 m_axis_tdata  output  DATA_WIDTH  byte to UART transmitter.
REQ-012 m_axis_tvalid  output  1  byte valid to UART transmitter.
REQ-013 m_axis_tready  input  1  UART transmitter ready.
REQ-014 grant_valid  output  1  high while a port owns the output.
REQ-015 grant_index  output  clog2(PORTS)  index of the owning port.

Function
REQ-016 FSM states SHALL be IDLE, HEADER and DATA.
REQ-017 In IDLE, when any s_axis_tvalid bit is high, the block SHALL pick the first requesting port, searching round-robin from last_grant+1 upward and wrapping modulo PORTS.
REQ-018 On that pick, the block SHALL register grant_index, set grant_valid=1, and next-state to HEADER if HEADER_EN=1, else to DATA.
REQ-019 In IDLE, m_axis_tvalid=0 and s_axis_tready=0 on all ports.
REQ-020 In HEADER, m_axis_tvalid=1 and m_axis_tdata=TAG_BASE|grant_index, held stable until the m_axis_tvalid && m_axis_tready handshake; on that handshake, next state is DATA.
REQ-021 In DATA, m_axis_tdata and m_axis_tvalid SHALL be driven combinationally from the granted port.
REQ-022 In DATA, s_axis_tready[grant_index]=m_axis_tready; every other s_axis_tready bit SHALL be 0.
REQ-023 In DATA, a handshake with s_axis_tlast[grant_index]=1 SHALL store last_grant<=grant_index, clear grant_valid and return to IDLE on the next cycle.
REQ-024 Grant SHALL be locked for the whole frame: other requesters and a granted port dropping tvalid mid-frame SHALL NOT change ownership.
REQ-025 Arbitration latency: first header/data beat valid one cycle after the request is seen in IDLE; one idle cycle occurs between consecutive frames.
REQ-026 Only requesters asserting tvalid in the IDLE cycle SHALL be considered; a single requester SHALL be re-granted back-to-back.
REQ-027 Bytes SHALL be passed through unmodified, without loss or duplication, and with no internal buffering beyond the tag byte.
REQ-028 m_axis_tready low SHALL stall the current beat indefinitely with data held stable.

Reset
REQ-029 While rst=1: state=IDLE, m_axis_tvalid=0, s_axis_tready=0, grant_valid=0, grant_index=0, last_grant=PORTS-1 (so port 0 has first priority).
REQ-030 rst asserted mid-frame SHALL abort the frame immediately, with no tag or trailing byte emitted after reset.
REQ-031 After reset, arbitration SHALL restart from port 0.

Verification
REQ-032 Single port: port 2 sends 3-byte frame 11,22,33 (tlast on 33), m_tready=1 -> m output A2,11,22,33; grant_index=2 throughout; grant_valid drops after 33.
REQ-033 All 4 ports request continuously with 1-byte frames -> tags A0,A1,A2,A3,A0 in order, one idle cycle between frames.
REQ-034 Backpressure: m_tready toggles 1/0 every cycle during a port 1 frame -> tag and data held stable while stalled; no byte lost or duplicated; s_tready[1] mirrors m_tready in DATA.
REQ-035 Grant lock: port 0 deasserts tvalid for 5 cycles mid-frame while port 3 requests -> port 0 keeps the grant; port 3 is served only after port 0's tlast beat.
REQ-036 rst pulsed during DATA of port 1 -> all outputs reach reset values on the next edge; next request from ports 1 and 0 together grants port 0.
REQ-037 HEADER_EN=0 build: port 3 frame 5A (tlast) -> m output 5A only, valid one cycle after the request.
